// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ============================================================================
// ahb3lite_interconnect_slave_arbiter
// Per-slave-port owner arbiter: highest priority wins, round-robin on ties,
// bursts and locked sequences are never split.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb3lite_interconnect_slave_arbiter #(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = $clog2(MASTERS-1)+1,
  parameter int IDX_BITS      = $clog2(MASTERS)
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [MASTERS-1:0]                 mst_HSEL,
  input  logic [MASTERS*PRIORITY_BITS-1:0]   mst_priority,
  input  logic [MASTERS*2-1:0]               mst_HTRANS,
  input  logic [MASTERS-1:0]                 mst_HMASTLOCK,
  input  logic                               slv_HREADY,
  output logic [MASTERS-1:0]                 grant_o,
  output logic [IDX_BITS-1:0]                grant_idx_o,
  output logic                               grant_valid_o,
  output logic                               locked_o
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_owned  = 2'd1;
  localparam logic [1:0] c_st_locked = 2'd2;

  localparam logic [IDX_BITS-1:0] c_rr_reset = IDX_BITS'(MASTERS-1);

  logic [1:0]          state_q,   state_d;
  logic [IDX_BITS-1:0] owner_q,   owner_d;
  logic [IDX_BITS-1:0] rr_last_q, rr_last_d;

  logic [PRIORITY_BITS-1:0] w_prio  [MASTERS];
  logic [1:0]               w_trans [MASTERS];
  logic [MASTERS-1:0]       w_req;
  logic [MASTERS-1:0]       w_cand;
  logic [PRIORITY_BITS-1:0] w_maxp;
  logic [IDX_BITS-1:0]      w_winner;
  logic [IDX_BITS-1:0]      w_scan;
  logic                     w_found;
  logic                     w_any_req;
  logic                     w_burst_hold;
  logic                     w_lock_hold;
  logic                     w_hold;
  logic                     w_arb;

  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_unpack
      assign w_prio[gi]  = mst_priority[gi*PRIORITY_BITS +: PRIORITY_BITS];
      assign w_trans[gi] = mst_HTRANS[gi*2 +: 2];
      assign w_req[gi]   = mst_HSEL[gi] & mst_HTRANS[gi*2+1];
    end
  endgenerate

  assign w_any_req = |w_req;

  always_comb begin
    w_maxp = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (w_req[i] && (w_prio[i] > w_maxp)) begin
        w_maxp = w_prio[i];
      end
    end
  end

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_cand[i] = w_req[i] && (w_prio[i] == w_maxp);
    end
  end

  // Scan upward from the slot after the last winner so ties rotate fairly.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_scan   = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      w_scan = IDX_BITS'((int'(rr_last_q) + k) % MASTERS);
      if (!w_found && w_cand[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
    end
  end

  // An owner that drops HSEL is addressing another slave, so its HTRANS no longer holds us.
  assign w_burst_hold = mst_HSEL[owner_q] & w_trans[owner_q][0];
  assign w_lock_hold  = mst_HMASTLOCK[owner_q] & (state_q == c_st_locked);
  assign w_hold       = (state_q != c_st_idle) & (w_burst_hold | w_lock_hold);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= c_st_idle;
      owner_q   <= '0;
      rr_last_q <= c_rr_reset;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    w_arb     = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (slv_HREADY && w_any_req) begin
          w_arb = 1'b1;
        end
      end
      c_st_owned, c_st_locked: begin
        if (!w_hold && slv_HREADY) begin
          if (w_any_req) begin
            w_arb = 1'b1;
          end else begin
            state_d = c_st_owned;
          end
        end
      end
      default: begin
        state_d = c_st_idle;
        owner_d = '0;
      end
    endcase
    if (w_arb) begin
      owner_d   = w_winner;
      rr_last_d = w_winner;
      state_d   = mst_HMASTLOCK[w_winner] ? c_st_locked : c_st_owned;
    end
  end

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    locked_o      = (state_q == c_st_locked);
    if (state_q != c_st_idle) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = owner_q;
      for (int i = 0; i < MASTERS; i++) begin
        grant_o[i] = (owner_q == IDX_BITS'(i));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// ============================================================================
// tb_ahb3lite_interconnect_slave_arbiter
// Directed self-checking bench for the three-master slave-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb3lite_interconnect_slave_arbiter;

  localparam int MASTERS = 3;
  localparam int PB      = 2;
  localparam int IB      = 2;

  logic                   HCLK;
  logic                   HRESETn;
  logic [MASTERS-1:0]     mst_HSEL;
  logic [MASTERS*PB-1:0]  mst_priority;
  logic [MASTERS*2-1:0]   mst_HTRANS;
  logic [MASTERS-1:0]     mst_HMASTLOCK;
  logic                   slv_HREADY;
  logic [MASTERS-1:0]     grant_o;
  logic [IB-1:0]          grant_idx_o;
  logic                   grant_valid_o;
  logic                   locked_o;

  int n_checks;
  int n_errors;

  ahb3lite_interconnect_slave_arbiter #(.MASTERS(MASTERS)) u_dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .mst_HSEL      (mst_HSEL),
    .mst_priority  (mst_priority),
    .mst_HTRANS    (mst_HTRANS),
    .mst_HMASTLOCK (mst_HMASTLOCK),
    .slv_HREADY    (slv_HREADY),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o),
    .locked_o      (locked_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Arguments ordered master2, master1, master0 to read like the packed vectors.
  task automatic set_prio(input logic [1:0] p2, input logic [1:0] p1, input logic [1:0] p0);
    mst_priority = {p2, p1, p0};
  endtask

  task automatic set_trans(input logic [1:0] t2, input logic [1:0] t1, input logic [1:0] t0);
    mst_HTRANS = {t2, t1, t0};
  endtask

  task automatic chk_owner(input string tag, input logic [2:0] g, input logic [1:0] idx,
                           input logic v, input logic lk);
    chk({tag, ".grant"}, 32'(grant_o), 32'(g));
    chk({tag, ".idx"},   32'(grant_idx_o), 32'(idx));
    chk({tag, ".valid"}, 32'(grant_valid_o), 32'(v));
    chk({tag, ".lock"},  32'(locked_o), 32'(lk));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    HRESETn       = 1'b0;
    mst_HSEL      = '0;
    mst_HMASTLOCK = '0;
    slv_HREADY    = 1'b1;
    set_prio(2'd0, 2'd0, 2'd0);
    set_trans(2'd0, 2'd0, 2'd0);

    // Reset held three cycles, then idle with HREADY high.
    tick(); tick(); tick();
    chk_owner("rst", 3'b000, 2'd0, 1'b0, 1'b0);
    HRESETn = 1'b1;
    tick(); tick();
    chk_owner("idle", 3'b000, 2'd0, 1'b0, 1'b0);

    // Priority win: master 1 has the highest priority.
    set_prio(2'd2, 2'd3, 2'd1);
    mst_HSEL = 3'b111;
    set_trans(2'd2, 2'd2, 2'd2);
    tick();
    chk_owner("prio", 3'b010, 2'd1, 1'b1, 1'b0);

    // Round-robin among equal priorities starting from a fresh reset.
    HRESETn = 1'b0;
    #1;
    HRESETn = 1'b1;
    set_prio(2'd2, 2'd2, 2'd2);
    tick(); chk("rr0", 32'(grant_idx_o), 32'd0);
    tick(); chk("rr1", 32'(grant_idx_o), 32'd1);
    tick(); chk("rr2", 32'(grant_idx_o), 32'd2);
    tick(); chk("rr3", 32'(grant_idx_o), 32'd0);
    tick(); chk("rr4", 32'(grant_idx_o), 32'd1);

    // Burst hold: master 0 owns, streams SEQ beats while master 2 outranks it.
    mst_HSEL = 3'b001;
    set_prio(2'd3, 2'd1, 2'd1);
    set_trans(2'd0, 2'd0, 2'd2);
    tick();
    chk("burst.own", 32'(grant_idx_o), 32'd0);
    mst_HSEL = 3'b101;
    set_trans(2'd2, 2'd0, 2'd3);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("burst.hold", 32'(grant_o), 32'b001);
    end
    set_trans(2'd2, 2'd0, 2'd0);
    tick();
    chk_owner("burst.end", 3'b100, 2'd2, 1'b1, 1'b0);

    // Locked ownership by master 1, then a stalled release.
    mst_HSEL = 3'b010;
    set_trans(2'd0, 2'd2, 2'd0);
    mst_HMASTLOCK = 3'b010;
    set_prio(2'd3, 2'd1, 2'd2);
    tick();
    chk_owner("lock.own", 3'b010, 2'd1, 1'b1, 1'b1);
    mst_HSEL = 3'b111;
    set_trans(2'd2, 2'd2, 2'd2);
    tick(); chk_owner("lock.hold0", 3'b010, 2'd1, 1'b1, 1'b1);
    tick(); chk_owner("lock.hold1", 3'b010, 2'd1, 1'b1, 1'b1);
    mst_HMASTLOCK = 3'b000;
    mst_HSEL = 3'b101;
    set_trans(2'd2, 2'd0, 2'd2);
    slv_HREADY = 1'b0;
    tick(); chk_owner("stall0", 3'b010, 2'd1, 1'b1, 1'b1);
    tick(); chk_owner("stall1", 3'b010, 2'd1, 1'b1, 1'b1);
    slv_HREADY = 1'b1;
    tick();
    chk_owner("lock.switch", 3'b100, 2'd2, 1'b1, 1'b0);

    // Reset asserted mid-lock clears outputs without waiting for a clock edge.
    mst_HSEL = 3'b001;
    set_trans(2'd0, 2'd0, 2'd2);
    mst_HMASTLOCK = 3'b001;
    tick();
    chk_owner("rlock.own", 3'b001, 2'd0, 1'b1, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_owner("rlock.async", 3'b000, 2'd0, 1'b0, 1'b0);
    tick();
    mst_HMASTLOCK = 3'b000;
    mst_HSEL = 3'b111;
    set_prio(2'd2, 2'd2, 2'd2);
    set_trans(2'd2, 2'd2, 2'd2);
    HRESETn = 1'b1;
    tick();
    chk_owner("rlock.tie", 3'b001, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb3lite_interconnect_slave_arbiter.md
Name: ahb3lite_interconnect_slave_arbiter

Overview:
Per-slave-port arbiter for the AHB3-Lite interconnect matrix. It picks which master owns a slave port from per-master HSEL/priority requests.
- Highest priority wins; ties among equal-priority masters are broken round-robin.
- Bursts and locked sequences are never split.
- The registered grant steers the slave-port address/data muxes and the HREADYOUT back-pressure to non-owning masters.

Parameters:
MASTERS, 3, number of masters connected to this slave port (>=2)
PRIORITY_BITS, $clog2(MASTERS-1)+1, width of each master priority field (derived; do not override)
IDX_BITS, $clog2(MASTERS), width of the grant index (derived)

Ports:
HCLK  input  1  system clock, all state on rising edge
HRESETn  input  1  asynchronous active-low reset
mst_HSEL  input  MASTERS  per-master select of this slave
mst_priority  input  MASTERS x PRIORITY_BITS  per-master priority, larger = higher
mst_HTRANS  input  MASTERS x 2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
mst_HMASTLOCK  input  MASTERS  per-master lock
slv_HREADY  input  1  HREADY of the slave port; arbitration only advances when high
grant_o  output  MASTERS  one-hot owner; all-zero when no owner
grant_idx_o  output  IDX_BITS  binary index of owner; 0 when no owner
grant_valid_o  output  1  an owner exists
locked_o  output  1  owner holds the port under HMASTLOCK

Behaviour:
- Reset (HRESETn=0, async): grant_o=0, grant_idx_o=0, grant_valid_o=0, locked_o=0, state=IDLE, rr_last=MASTERS-1 (so master 0 wins the first tie).
- Request vector: req[i] = mst_HSEL[i] & mst_HTRANS[i][1] (NONSEQ or SEQ).
- Winner selection (combinational):
  - maxp = highest mst_priority among set req bits.
  - Candidates = requesters with priority == maxp.
  - Winner = first candidate scanning upward from rr_last+1, wrapping at MASTERS-1 -> 0.
- Hold condition for the current owner o (any one of the following):
  - mst_HSEL[o] & mst_HTRANS[o] in {BUSY, SEQ} (burst in progress), or
  - mst_HMASTLOCK[o]=1 while state=LOCKED.
- Owner losing HSEL clears the burst hold regardless of its HTRANS (its HTRANS then targets another slave).
- Registered grant: decision on an HCLK edge with slv_HREADY=1; outputs change that edge. Latency request->grant = 1 cycle. No change of any output on an edge with slv_HREADY=0.
- States:
  - IDLE (no owner): on edge with slv_HREADY & |req -> grant winner; go LOCKED if mst_HMASTLOCK[winner], else OWNED. rr_last<=winner. Otherwise stay.
  - OWNED: if hold -> stay. Else, on slv_HREADY:
    - |req -> grant winner (may equal owner); LOCKED if winner locked; rr_last<=winner.
    - no req -> park: keep owner and grant_valid_o=1, state OWNED.
  - LOCKED: stay while mst_HMASTLOCK[owner]=1 or burst hold, even if higher-priority requests arrive. When both clear on an edge with slv_HREADY=1 -> arbitrate as in OWNED.
- Simultaneous events:
  - Owner NONSEQ and higher-priority request on the same edge -> higher priority wins.
  - Owner NONSEQ with a lower or equal-priority other requester -> round-robin decides (owner is included as a candidate).
- Priority changes take effect at the next arbitration edge only, never mid-burst.
- Reset mid-burst or mid-lock -> immediate return to reset values; no state is retained.
- locked_o = (state==LOCKED); grant_idx_o always consistent with grant_o.
- Fully synthesizable; no latches; MASTERS up to 16 meets one level of the existing priority tree plus a round-robin mask.

Test Plan:
1. Reset then idle: HRESETn low 3 cycles, all req 0 -> grant_o=0, grant_valid_o=0, locked_o=0; remain so with HREADY=1.
2. Priority win: MASTERS=3, prio={0:1,1:3,2:2}, all HSEL with NONSEQ, HREADY=1 -> next edge grant_o=3'b010, grant_idx_o=1.
3. Round-robin tie: all prio=2, all requesting NONSEQ each cycle, HREADY=1 -> grant_idx_o sequence 0,1,2,0,1.
4. Burst hold: master 0 granted, drives SEQ for 4 beats while master 2 (higher prio) requests -> grant stays 0 until master 0 drives IDLE/NONSEQ, then grant_idx_o=2 next edge.
5. Lock and HREADY stall: master 1 granted with HMASTLOCK=1 -> locked_o=1; higher-priority requests ignored; HREADY=0 for 2 cycles after lock drops -> no change; first HREADY=1 edge -> switch.
6. Reset mid-lock: assert HRESETn low during LOCKED -> outputs zero asynchronously; after release, the first tie goes to master 0.
